reg_lock_scoreboard: RTL and testbench

//  Owns the per-register write locks that gate instruction launch. Counts outstanding writes per

---
 rtl/maverickOne_pkg.sv | 19 +
 rtl/reg_lock_counter.sv | 63 ++++++
 rtl/reg_lock_scoreboard.sv | 170 +++++++++++++++++
 tb/tb_reg_lock_scoreboard.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maverickOne_pkg.sv
// Shared configuration and types for the register write-lock scoreboard.
package maverickOne_pkg;

    localparam int NUM_REGS        = 16;
    localparam int NUM_OUTSTANDING = 3;
    localparam int NUM_WB_PORTS    = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } reg_lock_state_e;

    // Counter width that can hold 0..nos plus one step of headroom for saturation checks.
    function automatic int lock_cnt_width(input int nos);
        return $clog2(nos + 2);
    endfunction

endpackage

// File: rtl/reg_lock_counter.sv
// One saturating up/down counter of outstanding writes for a single register.
// The increment is 0..1 and the decrement is 0..NWB per cycle; the result clamps to
// 0..NOS, and ovf_o/udf_o flag a clamp in the current cycle.
module reg_lock_counter
    import maverickOne_pkg::*;
#(
    parameter int NOS = NUM_OUTSTANDING,
    parameter int NWB = NUM_WB_PORTS,
    parameter int CW  = lock_cnt_width(NOS),
    parameter int DW  = $clog2(NWB + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic [DW-1:0] dec_i,
    output logic [CW-1:0] count_o,
    output logic          ovf_o,
    output logic          udf_o
);

    // Wide enough that count + inc never wraps and dec never exceeds its range.
    localparam int SW = CW + DW + 1;

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [SW-1:0] up_sum;
    logic [SW-1:0] down_sum;
    logic [SW-1:0] diff;

    // Net the increment against the decrement, then clamp into 0..NOS.
    always_comb begin
        up_sum     = SW'(count_reg) + SW'(inc_i);
        down_sum   = SW'(dec_i);
        diff       = '0;
        count_next = count_reg;
        ovf_o      = 1'b0;
        udf_o      = 1'b0;
        if (up_sum < down_sum) begin
            count_next = '0;
            udf_o      = 1'b1;
        end else begin
            diff = up_sum - down_sum;
            if (diff > SW'(NOS)) begin
                count_next = CW'(NOS);
                ovf_o      = 1'b1;
            end else begin
                count_next = diff[CW-1:0];
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/reg_lock_scoreboard.sv
// Per-register write-lock scoreboard feeding the instruction launcher.
// Counts outstanding writes per destination register, holds a global lock while a
// blocking instruction is in flight, and offers a drain handshake for flush quiescing.
// Optional feature macro: REG_LOCK_ERR_EN enables the sticky protocol error output;
// without it err_o is tied low and saturation behaves identically.
module reg_lock_scoreboard
    import maverickOne_pkg::*;
#(
    parameter int NR  = NUM_REGS,
    parameter int NOS = NUM_OUTSTANDING,
    parameter int NWB = NUM_WB_PORTS
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      launch_valid_i,
    input  logic                      launch_ready_i,
    input  logic [$clog2(NR)-1:0]     launch_rd_i,
    input  logic                      launch_wr_i,
    input  logic                      launch_blocking_i,
    input  logic [NWB-1:0]            wb_valid_i,
    input  logic [NWB*$clog2(NR)-1:0] wb_rd_i,
    input  logic                      blk_done_i,
    input  logic                      drain_req_i,
    output logic                      drain_ack_o,
    output logic [NR-1:0]             locks_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int RW = $clog2(NR);
    localparam int CW = lock_cnt_width(NOS);
    localparam int DW = $clog2(NWB + 1);

    logic            fire;
    logic [NR-1:0]   nonzero;
    logic [NR-1:0]   ovf_vec;
    logic [NR-1:0]   udf_vec;
    logic            blk_active_reg;
    logic            blk_active_next;
    logic            spurious_done;
    logic            force_lock;
    reg_lock_state_e state_reg;
    reg_lock_state_e state_next;

    assign fire = launch_valid_i & launch_ready_i;

    // x0 is never tracked, so its slot in every per-register vector is constant.
    assign nonzero[0] = 1'b0;
    assign ovf_vec[0] = 1'b0;
    assign udf_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NR; gi++) begin : g_cnt
            logic          inc;
            logic [DW-1:0] dec;
            logic [CW-1:0] cnt;

            assign inc = fire & launch_wr_i & (launch_rd_i == RW'(gi));

            // Count how many writeback ports retire a write to this register this cycle.
            always_comb begin
                dec = '0;
                for (int p = 0; p < NWB; p++) begin
                    if (wb_valid_i[p] && (wb_rd_i[p*RW +: RW] == RW'(gi))) begin
                        dec = dec + DW'(1);
                    end
                end
            end

            reg_lock_counter #(
                .NOS (NOS),
                .NWB (NWB),
                .CW  (CW),
                .DW  (DW)
            ) u_cnt (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .inc_i   (inc),
                .dec_i   (dec),
                .count_o (cnt),
                .ovf_o   (ovf_vec[gi]),
                .udf_o   (udf_vec[gi])
            );

            assign nonzero[gi] = |cnt;
        end
    endgenerate

    // A newly launched blocking instruction wins over a same-cycle retirement.
    always_comb begin
        blk_active_next = blk_active_reg;
        if (fire && launch_blocking_i) begin
            blk_active_next = 1'b1;
        end else if (blk_done_i) begin
            blk_active_next = 1'b0;
        end
    end

    assign spurious_done = blk_done_i & ~blk_active_reg;

    // Blocking-instruction flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blk_active_reg <= 1'b0;
        end else begin
            blk_active_reg <= blk_active_next;
        end
    end

    assign busy_o = (|nonzero) | blk_active_reg;

    // Drain FSM next-state: quiesce once nothing is outstanding, fall back when request drops.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            RUN: begin
                if (drain_req_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_req_i) begin
                    state_next = RUN;
                end else if (!busy_o) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!drain_req_i) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    assign drain_ack_o = (state_reg == DONE);
    assign force_lock  = blk_active_reg | (state_reg != RUN);
    assign locks_o     = nonzero | {NR{force_lock}};

`ifdef REG_LOCK_ERR_EN
    logic err_reg;

    // Sticky protocol error: any saturation or a retirement with nothing in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else if ((|ovf_vec) || (|udf_vec) || spurious_done) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    logic err_unused;

    assign err_unused = |{ovf_vec, udf_vec, spurious_done};
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_reg_lock_scoreboard.sv
// Self-checking bench for reg_lock_scoreboard: directed scenarios plus a randomized
// run compared against a behavioural per-register count model.
module tb_reg_lock_scoreboard;
    import maverickOne_pkg::*;

    localparam int NR  = NUM_REGS;
    localparam int NOS = NUM_OUTSTANDING;
    localparam int NWB = NUM_WB_PORTS;
    localparam int RW  = $clog2(NR);
`ifdef REG_LOCK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic                launch_valid_i = 1'b0;
    logic                launch_ready_i = 1'b1;
    logic [RW-1:0]       launch_rd_i = '0;
    logic                launch_wr_i = 1'b0;
    logic                launch_blocking_i = 1'b0;
    logic [NWB-1:0]      wb_valid_i = '0;
    logic [NWB*RW-1:0]   wb_rd_i = '0;
    logic                blk_done_i = 1'b0;
    logic                drain_req_i = 1'b0;
    logic                drain_ack_o;
    logic [NR-1:0]       locks_o;
    logic                busy_o;
    logic                err_o;

    int checks = 0;
    int fails  = 0;

    // Behavioural model: plain counts, a flag, a mode number (0 run, 1 drain, 2 done).
    int m_cnt[NR];
    bit m_blk;
    int m_mode;
    bit m_err;

    always #5 clk = ~clk;

    reg_lock_scoreboard dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .launch_valid_i    (launch_valid_i),
        .launch_ready_i    (launch_ready_i),
        .launch_rd_i       (launch_rd_i),
        .launch_wr_i       (launch_wr_i),
        .launch_blocking_i (launch_blocking_i),
        .wb_valid_i        (wb_valid_i),
        .wb_rd_i           (wb_rd_i),
        .blk_done_i        (blk_done_i),
        .drain_req_i       (drain_req_i),
        .drain_ack_o       (drain_ack_o),
        .locks_o           (locks_o),
        .busy_o            (busy_o),
        .err_o             (err_o)
    );

    function automatic bit exp_busy();
        bit b = m_blk;
        for (int r = 0; r < NR; r++) if (m_cnt[r] != 0) b = 1'b1;
        return b;
    endfunction

    function automatic logic [NR-1:0] exp_locks();
        logic [NR-1:0] l = '0;
        for (int r = 0; r < NR; r++)
            l[r] = (r != 0 && m_cnt[r] != 0) || m_blk || (m_mode != 0);
        return l;
    endfunction

    // Advance the model by one clock using the stimulus present at the edge.
    task automatic model_step();
        bit e = 1'b0;
        bit fire = launch_valid_i && launch_ready_i;
        int rd = int'(launch_rd_i);
        int w0 = int'(wb_rd_i[RW-1:0]);
        int w1 = int'(wb_rd_i[2*RW-1:RW]);
        int n;
        bit busy_before;
        if (rst_i) begin
            for (int r = 0; r < NR; r++) m_cnt[r] = 0;
            m_blk = 1'b0; m_mode = 0; m_err = 1'b0;
            return;
        end
        busy_before = exp_busy();
        case (m_mode)
            0: if (drain_req_i) m_mode = 1;
            1: if (!drain_req_i) m_mode = 0; else if (!busy_before) m_mode = 2;
            default: if (!drain_req_i) m_mode = 0;
        endcase
        for (int r = 1; r < NR; r++) begin
            n = m_cnt[r];
            if (fire && launch_wr_i && rd == r) n = n + 1;
            if (wb_valid_i[0] && w0 == r) n = n - 1;
            if (wb_valid_i[1] && w1 == r) n = n - 1;
            if (n > NOS) begin n = NOS; e = 1'b1; end
            if (n < 0)   begin n = 0;   e = 1'b1; end
            m_cnt[r] = n;
        end
        if (blk_done_i && !m_blk) e = 1'b1;
        if (fire && launch_blocking_i) m_blk = 1'b1;
        else if (blk_done_i)           m_blk = 1'b0;
        if (ERR_EN && e) m_err = 1'b1;
    endtask

    // Apply one cycle of stimulus, clock it, update the model, settle past the edge.
    task automatic cycle(input bit v = 0, input int rd = 0, input bit wr = 0, input bit blkg = 0,
                         input bit [1:0] wv = 2'b00, input int r0 = 0, input int r1 = 0,
                         input bit done = 0, input bit req = 0, input bit rst = 0, input bit rdy = 1);
        launch_valid_i    = v;
        launch_ready_i    = rdy;
        launch_rd_i       = RW'(rd);
        launch_wr_i       = wr;
        launch_blocking_i = blkg;
        wb_valid_i        = wv;
        wb_rd_i           = {RW'(r1), RW'(r0)};
        blk_done_i        = done;
        drain_req_i       = req;
        rst_i             = rst;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 5, 1, 1, 2'b00, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (locks_o !== '0) begin fails++; $display("FAIL reset_locks got %h want 0", locks_o); end
        checks++; if (drain_ack_o !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", drain_ack_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_o); end
        cycle();
    endtask

    task automatic test_launch_wb();
        cycle(1, 5, 1);
        checks++; if (locks_o !== 16'h0020) begin fails++; $display("FAIL launch_lock5 got %h want 0020", locks_o); end
        checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL launch_busy got %b want 1", busy_o); end
        cycle(); cycle();
        checks++; if (locks_o[5] !== 1'b1) begin fails++; $display("FAIL launch_hold5 got %b want 1", locks_o[5]); end
        cycle(0, 0, 0, 0, 2'b01, 5, 0);
        checks++; if (locks_o !== '0) begin fails++; $display("FAIL wb_clear5 got %h want 0", locks_o); end
        $display("launch_wb: locks=%h busy=%b", locks_o, busy_o);
    endtask

    task automatic test_net_out();
        cycle(1, 7, 1);
        cycle(1, 7, 1, 0, 2'b10, 0, 7);
        checks++; if (locks_o !== 16'h0080) begin fails++; $display("FAIL netout_lock7 got %h want 0080", locks_o); end
        cycle(0, 0, 0, 0, 2'b01, 7, 0);
        checks++; if (locks_o !== '0) begin fails++; $display("FAIL netout_count1 got %h want 0", locks_o); end
        $display("net_out: locks=%h", locks_o);
    endtask

    task automatic test_dual_wb();
        cycle(1, 3, 1);
        cycle(1, 3, 1);
        checks++; if (locks_o !== 16'h0008) begin fails++; $display("FAIL dual_lock3 got %h want 0008", locks_o); end
        cycle(0, 0, 0, 0, 2'b11, 3, 3);
        checks++; if (locks_o !== '0) begin fails++; $display("FAIL dual_clear3 got %h want 0", locks_o); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL dual_err got %b want 0", err_o); end
        $display("dual_wb: locks=%h err=%b", locks_o, err_o);
    endtask

    task automatic test_x0_underflow();
        cycle(1, 0, 1);
        checks++; if (locks_o !== '0) begin fails++; $display("FAIL x0_lock got %h want 0", locks_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL x0_busy got %b want 0", busy_o); end
        cycle(0, 0, 0, 0, 2'b01, 9, 0);
        checks++; if (locks_o !== '0) begin fails++; $display("FAIL udf_lock got %h want 0", locks_o); end
        checks++; if (err_o !== ERR_EN) begin fails++; $display("FAIL udf_err got %b want %b", err_o, ERR_EN); end
        cycle(1, 2, 1);
        checks++; if (locks_o !== 16'h0004) begin fails++; $display("FAIL udf_recount got %h want 0004", locks_o); end
        cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (err_o !== 1'b0 || locks_o !== '0) begin fails++; $display("FAIL udf_rst got err=%b locks=%h want 0/0", err_o, locks_o); end
        cycle();
        $display("x0_underflow: err_en=%b", ERR_EN);
    endtask

    task automatic test_blocking();
        cycle(1, 0, 0, 1);
        checks++; if (locks_o !== '1) begin fails++; $display("FAIL blk_set got %h want ffff", locks_o); end
        cycle(); cycle(); cycle();
        checks++; if (locks_o !== '1) begin fails++; $display("FAIL blk_hold got %h want ffff", locks_o); end
        cycle(0, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (locks_o !== '0 || busy_o !== 1'b0) begin fails++; $display("FAIL blk_clear got %h busy=%b want 0/0", locks_o, busy_o); end
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1, 2'b00, 0, 0, 1);
        checks++; if (locks_o !== '1) begin fails++; $display("FAIL blk_same_cycle got %h want ffff", locks_o); end
        cycle(0, 0, 0, 0, 2'b00, 0, 0, 1);
        checks++; if (locks_o !== '0) begin fails++; $display("FAIL blk_clear2 got %h want 0", locks_o); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL blk_err got %b want 0", err_o); end
        $display("blocking: locks=%h", locks_o);
    endtask

    task automatic test_drain();
        cycle(1, 4, 1);
        cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        checks++; if (locks_o !== '1 || drain_ack_o !== 1'b0) begin fails++; $display("FAIL drain_enter got %h ack=%b want ffff/0", locks_o, drain_ack_o); end
        cycle(0, 0, 0, 0, 2'b01, 4, 0, 0, 1);
        checks++; if (busy_o !== 1'b0 || drain_ack_o !== 1'b0) begin fails++; $display("FAIL drain_wb got busy=%b ack=%b want 0/0", busy_o, drain_ack_o); end
        cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        checks++; if (drain_ack_o !== 1'b1 || locks_o !== '1) begin fails++; $display("FAIL drain_done got ack=%b locks=%h want 1/ffff", drain_ack_o, locks_o); end
        cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        checks++; if (drain_ack_o !== 1'b1) begin fails++; $display("FAIL drain_hold got ack=%b want 1", drain_ack_o); end
        cycle();
        checks++; if (drain_ack_o !== 1'b0 || locks_o !== '0) begin fails++; $display("FAIL drain_exit got ack=%b locks=%h want 0/0", drain_ack_o, locks_o); end
        $display("drain: ack=%b locks=%h", drain_ack_o, locks_o);
    endtask

    task automatic test_drain_reset();
        cycle(1, 4, 1);
        cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        checks++; if (locks_o !== '1) begin fails++; $display("FAIL drstr_enter got %h want ffff", locks_o); end
        cycle(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1);
        checks++; if (locks_o !== '0 || drain_ack_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL drstr_reset got locks=%h ack=%b busy=%b want 0/0/0", locks_o, drain_ack_o, busy_o);
        end
        cycle();
        $display("drain_reset: locks=%h", locks_o);
    endtask

    task automatic test_random();
        bit req = 1'b0;
        int bad = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) req = ~req;
            cycle($urandom_range(0, 1), $urandom_range(0, NR-1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3) & $urandom_range(0, 3)),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 19) == 0,
                  req, $urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);
            checks++; if (locks_o !== exp_locks()) begin fails++; bad++; $display("FAIL rand_locks cyc %0d got %h want %h", i, locks_o, exp_locks()); end
            checks++; if (busy_o !== exp_busy()) begin fails++; bad++; $display("FAIL rand_busy cyc %0d got %b want %b", i, busy_o, exp_busy()); end
            checks++; if (drain_ack_o !== (m_mode == 2)) begin fails++; bad++; $display("FAIL rand_ack cyc %0d got %b want %b", i, drain_ack_o, m_mode == 2); end
            checks++; if (err_o !== m_err) begin fails++; bad++; $display("FAIL rand_err cyc %0d got %b want %b", i, err_o, m_err); end
            if (bad > 20) break;
        end
        $display("random: done, mismatching cycles reported above");
    endtask

    initial begin
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
        m_blk = 1'b0; m_mode = 0; m_err = 1'b0;
        test_reset();
        test_launch_wb();
        test_net_out();
        test_dual_wb();
        test_x0_underflow();
        test_blocking();
        test_drain();
        test_drain_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
